// File: rtl/mp_skip_add_ctrl_if.sv
// Request/response bundle for mp_skip_add_ctrl: operands and start in, sum, carry and status out.
// MP_SKIP_ADD_SUB_EN adds the SUB select alongside the operands.
interface mp_skip_add_ctrl_if #(parameter int NWORDS = 4);
    logic                  start;
    logic [8*NWORDS-1:0]   A;
    logic [8*NWORDS-1:0]   B;
    logic                  CIN;
`ifdef MP_SKIP_ADD_SUB_EN
    logic                  SUB;
`endif
    logic                  busy;
    logic                  done;
    logic [8*NWORDS-1:0]   S;
    logic                  COUT;

`ifdef MP_SKIP_ADD_SUB_EN
    modport master (output start, A, B, CIN, SUB, input busy, done, S, COUT);
    modport slave  (input start, A, B, CIN, SUB, output busy, done, S, COUT);
`else
    modport master (output start, A, B, CIN, input busy, done, S, COUT);
    modport slave  (input start, A, B, CIN, output busy, done, S, COUT);
`endif
endinterface

// File: rtl/mp_skip_add_ctrl.sv
// Multi-precision adder: walks NWORDS operand bytes LSB-first through one 8-bit carry-skip slice.
// Build option MP_SKIP_ADD_SUB_EN enables A-B via the SUB input.
//
// state | meaning
// IDLE  | waiting for start; S/COUT hold the last result
// RUN   | one byte per cycle through the slice, carry chained in carry_q
// DONE  | one-cycle done pulse, result valid
module mp_skip_add_ctrl #(
    parameter int NWORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    mp_skip_add_ctrl_if.slave bus
);
    localparam int W  = 8 * NWORDS;
    localparam int CW = $clog2(NWORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      a_byte, b_byte;
    logic [8:0]      slice;
`ifdef MP_SKIP_ADD_SUB_EN
    logic            sub_q, sub_d;
`endif

    // Two 4-bit ripple groups; a group whose bits all propagate forwards its carry-in directly.
    function automatic logic [8:0] skip_add8(input logic [7:0] a, input logic [7:0] b,
                                             input logic cin);
        logic [7:0] sum;
        logic       gc, rc, p;
        sum = '0;
        gc  = cin;
        for (int g = 0; g < 2; g++) begin
            rc = gc;
            p  = 1'b1;
            for (int i = 4 * g; i < 4 * g + 4; i++) begin
                sum[i] = a[i] ^ b[i] ^ rc;
                rc     = (a[i] & b[i]) | ((a[i] ^ b[i]) & rc);
                p      = p & (a[i] ^ b[i]);
            end
            gc = rc | (p & gc);
        end
        return {gc, sum};
    endfunction

    always_comb begin
        a_byte = a_q[{cnt_q, 3'b000} +: 8];
`ifdef MP_SKIP_ADD_SUB_EN
        b_byte = sub_q ? ~b_q[{cnt_q, 3'b000} +: 8] : b_q[{cnt_q, 3'b000} +: 8];
`else
        b_byte = b_q[{cnt_q, 3'b000} +: 8];
`endif
        slice  = skip_add8(a_byte, b_byte, carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef MP_SKIP_ADD_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    cnt_d   = '0;
`ifdef MP_SKIP_ADD_SUB_EN
                    sub_d   = bus.SUB;
                    carry_d = bus.SUB ? 1'b1 : bus.CIN;
`else
                    carry_d = bus.CIN;
`endif
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[{cnt_q, 3'b000} +: 8] = slice[7:0];
                carry_d = slice[8];
                if (cnt_q == CW'(NWORDS - 1)) begin
                    cout_d  = slice[8];
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MP_SKIP_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MP_SKIP_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.S    = s_q;
    assign bus.COUT = cout_q;
endmodule

// File: tb/tb_mp_skip_add_ctrl.sv
// Directed and random bench for mp_skip_add_ctrl; expected results come from plain wide arithmetic.
// Honours MP_SKIP_ADD_SUB_EN when the design is built with it.
module tb_mp_skip_add_ctrl;
    localparam int NW = 4;
    localparam int W  = 8 * NW;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    mp_skip_add_ctrl_if #(.NWORDS(NW)) bus();
    mp_skip_add_ctrl #(.NWORDS(NW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    endfunction

    // Launch one op, scramble the inputs mid-flight, and check the fixed-latency timeline.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input string tag);
        logic [W:0] exp;
        logic       eff_sub;
`ifdef MP_SKIP_ADD_SUB_EN
        eff_sub = sub;
`else
        eff_sub = 1'b0;
`endif
        exp = model(a, b, cin, eff_sub);
        @(negedge clk);
        bus.A = a; bus.B = b; bus.CIN = cin; bus.start = 1'b1;
`ifdef MP_SKIP_ADD_SUB_EN
        bus.SUB = sub;
`endif
        @(negedge clk);
        bus.start = 1'b0; bus.A = ~a; bus.B = $urandom; bus.CIN = ~cin;
`ifdef MP_SKIP_ADD_SUB_EN
        bus.SUB = ~sub;
`endif
        for (int i = 0; i < NW; i++) begin
            chk({tag, "_busy"}, (W+1)'({bus.busy, bus.done}), (W+1)'(2'b10));
            @(negedge clk);
        end
        chk({tag, "_done"}, (W+1)'({bus.busy, bus.done}), (W+1)'(2'b01));
        chk({tag, "_sum"}, {bus.COUT, bus.S}, exp);
        @(negedge clk);
        chk({tag, "_end"}, (W+1)'({bus.busy, bus.done}), (W+1)'(2'b00));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.CIN = 1'b0;
`ifdef MP_SKIP_ADD_SUB_EN
        bus.SUB = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_flags", (W+1)'({bus.busy, bus.done}), (W+1)'(2'b00));
            chk("idle_sum", {bus.COUT, bus.S}, '0);
        end

        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, "carry_chain");
        chk("carry_chain_const", {bus.COUT, bus.S}, {1'b1, 32'h00000000});
        run_op(32'h12F0F0FF, 32'h000F0F00, 1'b1, 1'b0, "skip_path");
        chk("skip_path_const", {bus.COUT, bus.S}, {1'b0, 32'h13000000});

        // start held high throughout; second op accepted once back in IDLE
        @(negedge clk);
        bus.A = 32'h5; bus.B = 32'h3; bus.CIN = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.A = 32'h10;
        for (int i = 0; i < NW; i++) begin
            chk("hold_busy", (W+1)'({bus.busy, bus.done}), (W+1)'(2'b10));
            @(negedge clk);
        end
        chk("hold_done", (W+1)'({bus.busy, bus.done}), (W+1)'(2'b01));
        chk("hold_sum", {bus.COUT, bus.S}, {1'b0, 32'h00000008});
        @(negedge clk);
        chk("hold_idle", (W+1)'({bus.busy, bus.done}), (W+1)'(2'b00));
        @(negedge clk);
        chk("hold_restart", (W+1)'({bus.busy, bus.done}), (W+1)'(2'b10));
        bus.start = 1'b0;
        for (int i = 1; i < NW; i++) begin
            @(negedge clk);
            chk("hold2_busy", (W+1)'({bus.busy, bus.done}), (W+1)'(2'b10));
        end
        @(negedge clk);
        chk("hold2_done", (W+1)'({bus.busy, bus.done}), (W+1)'(2'b01));
        chk("hold2_sum", {bus.COUT, bus.S}, {1'b0, 32'h00000013});

        // reset during the second RUN cycle aborts with no done
        @(negedge clk);
        bus.A = 32'hFFFFFFFF; bus.B = 32'h1; bus.CIN = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_flags", (W+1)'({bus.busy, bus.done}), (W+1)'(2'b00));
        chk("abort_sum", {bus.COUT, bus.S}, '0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_quiet", (W+1)'({bus.busy, bus.done}), (W+1)'(2'b00));
        end

        // reset and start on the same edge: start dropped
        rst = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_start_busy", (W+1)'({bus.busy, bus.done}), (W+1)'(2'b00));
        @(negedge clk);
        chk("rst_start_after", (W+1)'({bus.busy, bus.done}), (W+1)'(2'b00));

`ifdef MP_SKIP_ADD_SUB_EN
        run_op(32'h5, 32'h7, 1'b1, 1'b1, "sub_neg");
        chk("sub_neg_const", {bus.COUT, bus.S}, {1'b0, 32'hFFFFFFFE});
        run_op(32'h7, 32'h5, 1'b0, 1'b1, "sub_pos");
        chk("sub_pos_const", {bus.COUT, bus.S}, {1'b1, 32'h00000002});
`endif

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = (n % 4 == 0) ? ~ra : W'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
